serial_mag_comparator: RTL and testbench
========================================

# serial_mag_comparator

Multi-cycle magnitude comparator for WIDTH-bit unsigned operands. It walks the operands two bits per cycle, MSB digit first, and compares each 2-bit digit pair with the same eq/gt/lt slice logic as the team's 2-bit ternary comparator. It stops at the first unequal digit. The block sits directly upstream of that 2-bit comparator stage: it feeds it one digit pair per cycle and folds its flags into a registered word-level result, delivered through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥2; digit count D = WIDTH/2.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse; result valid.
- a_eq_b  output  1  registered result A==B.
- a_gt_b  output  1  registered result A>B.
- a_lt_b  output  1  registered result A<B.
- ndig  output  $clog2(D)+1  digits examined for the last result (1..D).

## Operation
- States: IDLE, CMP, DONE.
- IDLE:
  - start=1 → latch a_r=a, b_r=b.
  - Set idx=D-1.
  - Clear a_eq_b, a_gt_b, a_lt_b and ndig to 0.
  - Go to CMP.
  - start=0 → stay; outputs hold the last result.
- CMP, each cycle:
  - Digit slice = a_r[2*idx+1:2*idx] vs b_r[2*idx+1:2*idx], unsigned compare.
  - ndig increments each cycle.
  - Slice gt → a_gt_b=1, go to DONE.
  - Slice lt → a_lt_b=1, go to DONE.
  - Slice eq and idx==0 → a_eq_b=1, go to DONE.
  - Slice eq and idx>0 → idx decrements, stay in CMP.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Result flags:
  - Exactly one flag is high after DONE.
  - All three are 0 from the accepting edge until the result edge.
  - Flags and ndig hold until the next accepted start or reset.
- Inputs a/b changing after the accepting edge have no effect.
- start is ignored in CMP and DONE; no queuing.
- start held high continuously starts a new comparison on every IDLE cycle.

## Timing
- Edge E0: start sampled in IDLE. busy=1 from after E0.
- Edges E1..Ek: examine digits 1..k, where k = 1 + number of leading equal digits, and k ≤ D.
- After Ek:
  - State DONE, done=1, busy=0.
  - Flags and ndig=k are valid.
- After Ek+1: IDLE, done=0.
- Next start is accepted at earliest on Ek+2.
- Latency from start edge to done high: k cycles (min 1, max D). Throughput: one compare per k+2 cycles.
- Reset values: state IDLE, busy=0, done=0, a_eq_b=0, a_gt_b=0, a_lt_b=0, ndig=0, idx=0, a_r=0, b_r=0.
- Reset in any state, including mid-CMP or in DONE:
  - Next edge forces the reset values.
  - The in-flight comparison is discarded; no done pulse.
- rst and start both high: rst wins.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1 → busy=0, done=0, flags=000, ndig=0.
- Early exit, WIDTH=8: start with a=8'hC5, b=8'h35 (MSB digit 11 vs 00).
  - Done pulses 1 cycle after the start edge.
  - a_gt_b=1, ndig=1.
  - busy high for exactly 1 cycle.
- Full walk, equal: a=8'h5A, b=8'h5A → done after 4 cycles, a_eq_b=1, ndig=4.
- Full walk, LSB decides: a=8'h12, b=8'h13 → done after 4 cycles, a_lt_b=1, ndig=4.
- Handshake:
  - Pulse start with new operands during CMP and again during DONE → both ignored; first result unchanged.
  - start held high → next compare accepted on the cycle after done; flags read 000 until its result.
- Reset mid-op: start a=8'h12, b=8'h13, assert rst on the 2nd CMP cycle.
  - No done pulse; all outputs return to reset values.
  - A fresh start with a=8'h01, b=8'h00 completes with a_gt_b=1, ndig=4.
- Additionally, at WIDTH=2, loop over all 16 (a,b) pairs: flags must match the a==b / a>b / a<b truth table, with ndig=1 every time.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks two operands one 2-bit digit per cycle,
// MSB digit first, and stops at the first unequal digit. Results sit behind a start/busy/done handshake.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   output logic                      busy,
   output logic                      done,
   output logic                      a_eq_b,
   output logic                      a_gt_b,
   output logic                      a_lt_b,
   output logic [$clog2(WIDTH/2):0]  ndig
);

   localparam int D  = WIDTH / 2;
   localparam int NW = $clog2(D) + 1;
   localparam int IW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 2-bit digit slice compare, same eq/gt/lt rule as the downstream comparator; returns {gt, lt, eq}
   function automatic logic [2:0] dig_cmp(input logic [1:0] x, input logic [1:0] y);
      dig_cmp = {(x > y), (x < y), (x == y)};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_r_q, a_r_d, b_r_q, b_r_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NW-1:0]    ndig_q, ndig_d;
   logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [1:0]       a_dig_s, b_dig_s;
   logic [2:0]       slice_s;

   // Next-state, digit selection and result folding
   always_comb begin
      state_d = state_q;
      a_r_d   = a_r_q;
      b_r_d   = b_r_q;
      idx_d   = idx_q;
      ndig_d  = ndig_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      a_dig_s = 2'(a_r_q >> {idx_q, 1'b0});
      b_dig_s = 2'(b_r_q >> {idx_q, 1'b0});
      slice_s = dig_cmp(a_dig_s, b_dig_s);
      case (state_q)
         IDLE: begin
            if (start) begin
               a_r_d   = a;
               b_r_d   = b;
               idx_d   = IW'(D - 1);
               ndig_d  = {NW{1'b0}};
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = CMP;
            end else begin
               state_d = IDLE;
            end
         end
         CMP: begin
            ndig_d = ndig_q + NW'(1);
            if (slice_s[2]) begin
               gt_d    = 1'b1;
               state_d = DONE;
            end else if (slice_s[1]) begin
               lt_d    = 1'b1;
               state_d = DONE;
            end else if (idx_q == {IW{1'b0}}) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = CMP;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CMP);
      done_d = (state_d == DONE);
   end

   // State and result registers; synchronous reset discards any in-flight compare
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_r_q   <= {WIDTH{1'b0}};
         b_r_q   <= {WIDTH{1'b0}};
         idx_q   <= {IW{1'b0}};
         ndig_q  <= {NW{1'b0}};
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_r_q   <= a_r_d;
         b_r_q   <= b_r_d;
         idx_q   <= idx_d;
         ndig_q  <= ndig_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign a_eq_b = eq_q;
   assign a_gt_b = gt_q;
   assign a_lt_b = lt_q;
   assign ndig   = ndig_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized self-checking bench for serial_mag_comparator at WIDTH=8 and WIDTH=2,
// checked against a digit-walk reference model computed with plain arithmetic.
module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = 8'h00, b = 8'h00;
   logic       busy, done, a_eq_b, a_gt_b, a_lt_b;
   logic [2:0] ndig;

   logic       start2 = 1'b0;
   logic [1:0] a2 = 2'b00, b2 = 2'b00;
   logic       busy2, done2, eq2, gt2, lt2;
   logic [0:0] ndig2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .ndig(ndig)
   );

   serial_mag_comparator #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .a_eq_b(eq2), .a_gt_b(gt2), .a_lt_b(lt2), .ndig(ndig2)
   );

   // Digits examined: one more than the count of leading equal digits, capped at the digit count
   function automatic int model_k(input int x, input int y, input int nd);
      for (int i = nd - 1; i >= 0; i--) begin
         if (((x >> (2 * i)) & 3) != ((y >> (2 * i)) & 3)) return nd - i;
      end
      return nd;
   endfunction

   function automatic logic [2:0] model_flags(input int x, input int y);
      return {(x == y), (x > y), (x < y)};
   endfunction

   // Drives one compare on the 8-bit instance and records what the handshake did
   task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, output int lat,
                          output int busy_cnt, output int early_flags, output bit done_after);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      lat = 0; busy_cnt = 0; early_flags = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         if ({a_eq_b, a_gt_b, a_lt_b} !== 3'b000) early_flags++;
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      done_after = done;
   endtask

   task automatic check_cmp8(input string name, input logic [7:0] av, input logic [7:0] bv);
      int lat, bc, ef, k;
      bit da;
      logic [2:0] ef3;
      k   = model_k(int'(av), int'(bv), 4);
      ef3 = model_flags(int'(av), int'(bv));
      run_cmp(av, bv, lat, bc, ef, da);
      checks++;
      if ({a_eq_b, a_gt_b, a_lt_b} !== ef3) begin
         failures++;
         $display("FAIL %s flags a=%h b=%h got=%b exp=%b", name, av, bv, {a_eq_b, a_gt_b, a_lt_b}, ef3);
      end
      checks++;
      if (ndig !== 3'(k)) begin
         failures++;
         $display("FAIL %s ndig a=%h b=%h got=%0d exp=%0d", name, av, bv, ndig, k);
      end
      checks++;
      if (lat != k || bc != k) begin
         failures++;
         $display("FAIL %s latency a=%h b=%h lat=%0d busy=%0d exp=%0d", name, av, bv, lat, bc, k);
      end
      checks++;
      if (ef != 0 || da !== 1'b0) begin
         failures++;
         $display("FAIL %s handshake early_flags=%0d done_after=%b exp 0/0", name, ef, da);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; start = 1'b1; start2 = 1'b1; a = 8'hC5; b = 8'h35;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, a_eq_b, a_gt_b, a_lt_b, ndig} !== 8'b0 ||
          {busy2, done2, eq2, gt2, lt2, ndig2} !== 6'b0) begin
         failures++;
         $display("FAIL reset got8=%b got2=%b exp=0", {busy, done, a_eq_b, a_gt_b, a_lt_b, ndig},
                  {busy2, done2, eq2, gt2, lt2, ndig2});
      end
      rst = 1'b0; start = 1'b0; start2 = 1'b0;
   endtask

   task automatic test_directed;
      check_cmp8("early_exit", 8'hC5, 8'h35);
      check_cmp8("full_eq", 8'h5A, 8'h5A);
      check_cmp8("lsb_decides", 8'h12, 8'h13);
   endtask

   task automatic test_handshake;
      int n;
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h13;
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1; a = 8'h00; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b001 || ndig !== 3'd4) begin
         failures++;
         $display("FAIL ignore_start done=%b busy=%b flags=%b ndig=%0d exp 0 0 001 4",
                  done, busy, {a_eq_b, a_gt_b, a_lt_b}, ndig);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_idle busy=%b exp=0", busy);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      @(negedge clk);
      start = 1'b1; a = 8'hC5; b = 8'h35;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || a_gt_b !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first done=%b gt=%b exp 1 1", done, a_gt_b);
      end
      a = 8'h12; b = 8'h13;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b010) begin
         failures++;
         $display("FAIL b2b_idle busy=%b done=%b flags=%b exp 0 0 010", busy, done, {a_eq_b, a_gt_b, a_lt_b});
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || {a_eq_b, a_gt_b, a_lt_b} !== 3'b000) begin
         failures++;
         $display("FAIL b2b_accept busy=%b flags=%b exp 1 000", busy, {a_eq_b, a_gt_b, a_lt_b});
      end
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 4 || a_lt_b !== 1'b1 || ndig !== 3'd4) begin
         failures++;
         $display("FAIL b2b_second lat=%0d lt=%b ndig=%0d exp 4 1 4", n, a_lt_b, ndig);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int dseen;
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h13;
      @(negedge clk);
      start = 1'b0;
      dseen = (done === 1'b1) ? 1 : 0;
      @(negedge clk);
      if (done === 1'b1) dseen++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if (done === 1'b1) dseen++;
      checks++;
      if (dseen != 0 || {busy, done, a_eq_b, a_gt_b, a_lt_b, ndig} !== 8'b0) begin
         failures++;
         $display("FAIL reset_mid done_seen=%0d outs=%b exp 0 0", dseen, {busy, done, a_eq_b, a_gt_b, a_lt_b, ndig});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_late done=%b exp=0", done);
      end
      check_cmp8("after_reset", 8'h01, 8'h00);
   endtask

   task automatic test_random;
      logic [7:0] av, bv;
      for (int i = 0; i < 40; i++) begin
         av = 8'($urandom);
         case ($urandom_range(0, 2))
            0:       bv = 8'($urandom);
            1:       bv = av ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
            default: bv = av;
         endcase
         check_cmp8("random", av, bv);
      end
   endtask

   task automatic test_width2;
      int n;
      for (int x = 0; x < 4; x++) begin
         for (int y = 0; y < 4; y++) begin
            @(negedge clk);
            start2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
            @(negedge clk);
            start2 = 1'b0;
            n = 0;
            while (done2 !== 1'b1 && n < 10) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if ({eq2, gt2, lt2} !== model_flags(x, y) || ndig2 !== 1'b1 || n != model_k(x, y, 1)) begin
               failures++;
               $display("FAIL w2 a=%0d b=%0d flags=%b exp=%b ndig=%0d lat=%0d exp 1",
                        x, y, {eq2, gt2, lt2}, model_flags(x, y), ndig2, n);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_handshake;
      test_back_to_back;
      test_reset_mid;
      test_random;
      test_width2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
